// File: rtl/jtyiear_vlm_if.sv
// VLM5030 speech chip glue: CPU data latch and control register, start-pulse
// stretcher, speech ROM fetch with a one-byte buffer, and busy synchroniser.
//
// Start FSM
//   state    | meaning
//   ST_IDLE  | vlm_st low, waiting for a rising edge of st_req
//   ST_PULSE | vlm_st high, counting vlm_cen ticks up to ST_MIN
//   ST_HOLD  | vlm_st high, minimum width met, held until st_req clears
module jtyiear_vlm_if #(
    parameter int ST_MIN = 4,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_cen,
    input  logic          vlm_cen,
    input  logic          cpu_rnw,
    input  logic [7:0]    cpu_dout,
    input  logic          data_cs,
    input  logic          ctrl_cs,
    input  logic [AW-1:0] vlm_a,
    input  logic          vlm_me_l,
    input  logic          vlm_bsy,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [7:0]    vlm_din,
    output logic          vlm_st,
    output logic          vlm_rst,
    output logic          vlm_vcu,
    output logic          bsy_rd,
    output logic          miss
);

    localparam int CW = $clog2(ST_MIN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } st_t;

    st_t           state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [7:0]    data_q;
    logic          st_req, st_req_d;
    logic          cpu_wr, data_wr, ctrl_wr;
    logic          rst_eff, req_rise;
    logic          init_q, a_chg, valid;
    logic [7:0]    buf_q;
    logic          bsy_s1;

    assign cpu_wr   = cpu_cen & ~cpu_rnw;
    assign data_wr  = cpu_wr & data_cs;
    assign ctrl_wr  = cpu_wr & ctrl_cs;
    // A write that sets the reset bit kills the start pulse on that same edge
    assign rst_eff  = vlm_rst | (ctrl_wr & cpu_dout[0]);
    assign req_rise = st_req & ~st_req_d;
    assign cnt_inc  = cnt + 1'b1;
    // The first clock after reset always counts as an address change so a
    // fetch starts for whatever vlm_a is present at release
    assign a_chg    = ~init_q | (vlm_a != rom_addr);
    assign vlm_din  = vlm_me_l ? data_q : buf_q;

    // CPU-visible data latch and control register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= 8'h00;
            vlm_rst  <= 1'b0;
            st_req   <= 1'b0;
            vlm_vcu  <= 1'b0;
            st_req_d <= 1'b0;
        end else begin
            st_req_d <= st_req;
            if (data_wr) data_q <= cpu_dout;
            if (ctrl_wr) begin
                vlm_rst <= cpu_dout[0];
                st_req  <= cpu_dout[1];
                vlm_vcu <= cpu_dout[2];
            end
        end
    end

    // Start FSM state, counter and registered vlm_st
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            vlm_st <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            vlm_st <= (state_nx != ST_IDLE);
        end
    end

    // Start FSM next state; the reset bit overrides every transition
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (rst_eff) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_rise) begin
                        state_nx = ST_PULSE;
                        cnt_nx   = '0;
                    end
                end
                ST_PULSE: begin
                    if (vlm_cen) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == CW'(ST_MIN))
                            state_nx = st_req ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!st_req) state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // ROM fetch: track vlm_a, request on change, capture matching data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            init_q   <= 1'b0;
            rom_cs   <= 1'b0;
            valid    <= 1'b0;
            buf_q    <= 8'h00;
        end else begin
            rom_addr <= vlm_a;
            init_q   <= 1'b1;
            if (a_chg) begin
                rom_cs <= 1'b1;
                valid  <= 1'b0;
            end else if (rom_ok && rom_cs) begin
                buf_q  <= rom_data;
                valid  <= 1'b1;
                rom_cs <= 1'b0;
            end
        end
    end

    // Sticky miss flag: the chip sampled the bus before the buffer was ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss <= 1'b0;
        end else begin
            if (ctrl_wr) miss <= 1'b0;
            if (vlm_cen && !vlm_me_l && !valid) miss <= 1'b1;
        end
    end

    // Two-flop synchroniser for the busy line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bsy_s1 <= 1'b0;
            bsy_rd <= 1'b0;
        end else begin
            bsy_s1 <= vlm_bsy;
            bsy_rd <= bsy_s1;
        end
    end

endmodule

// File: tb/tb_jtyiear_vlm_if.sv
// Bench for jtyiear_vlm_if: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the interface.
module tb_jtyiear_vlm_if;

    localparam int ST_MIN = 4;
    localparam int AW     = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cpu_cen = 1'b0;
    logic          vlm_cen = 1'b0;
    logic          cpu_rnw = 1'b1;
    logic [7:0]    cpu_dout = 8'h00;
    logic          data_cs = 1'b0;
    logic          ctrl_cs = 1'b0;
    logic [AW-1:0] vlm_a = '0;
    logic          vlm_me_l = 1'b1;
    logic          vlm_bsy = 1'b0;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok = 1'b0;
    logic [7:0]    vlm_din;
    logic          vlm_st, vlm_rst, vlm_vcu, bsy_rd, miss;

    jtyiear_vlm_if #(.ST_MIN(ST_MIN), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .vlm_cen(vlm_cen),
        .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout), .data_cs(data_cs),
        .ctrl_cs(ctrl_cs), .vlm_a(vlm_a), .vlm_me_l(vlm_me_l),
        .vlm_bsy(vlm_bsy), .rom_addr(rom_addr), .rom_cs(rom_cs),
        .rom_data(rom_data), .rom_ok(rom_ok), .vlm_din(vlm_din),
        .vlm_st(vlm_st), .vlm_rst(vlm_rst), .vlm_vcu(vlm_vcu),
        .bsy_rd(bsy_rd), .miss(miss)
    );

    always #5 clk = ~clk;

    // The ROM always answers with data belonging to the address it is given
    assign rom_data = rom_addr[7:0] ^ rom_addr[15:8] ^ 8'h5A;

    int total = 0;
    int bad = 0;
    int st_ticks = 0;

    // behavioural model
    bit [7:0]    m_data, m_buf;
    bit          m_rst, m_req, m_vcu, m_req_prev;
    bit          m_active, m_pulsing;
    int          m_ticks;
    bit [AW-1:0] m_addr;
    bit          m_init, m_cs, m_valid, m_miss, m_b1, m_b2;

    task automatic model_reset();
        m_data = 0; m_buf = 0; m_rst = 0; m_req = 0; m_vcu = 0; m_req_prev = 0;
        m_active = 0; m_pulsing = 0; m_ticks = 0; m_addr = 0; m_init = 0;
        m_cs = 0; m_valid = 0; m_miss = 0; m_b1 = 0; m_b2 = 0;
    endtask

    task automatic model_edge();
        bit wr, cwr, kill, rise, chg, n_miss;
        wr   = cpu_cen && !cpu_rnw;
        cwr  = wr && ctrl_cs;
        kill = m_rst || (cwr && cpu_dout[0]);
        rise = m_req && !m_req_prev;
        // start pulse: at least ST_MIN ticks, then follows the request
        if (kill) begin
            m_active = 0; m_pulsing = 0; m_ticks = 0;
        end else if (!m_active) begin
            if (rise) begin m_active = 1; m_pulsing = 1; m_ticks = 0; end
        end else if (m_pulsing) begin
            if (vlm_cen) m_ticks++;
            if (m_ticks == ST_MIN) begin m_pulsing = 0; m_active = m_req; end
        end else if (!m_req) begin
            m_active = 0;
        end
        m_req_prev = m_req;
        if (cwr) begin m_rst = cpu_dout[0]; m_req = cpu_dout[1]; m_vcu = cpu_dout[2]; end
        if (wr && data_cs) m_data = cpu_dout;
        n_miss = m_miss;
        if (cwr) n_miss = 0;
        if (vlm_cen && !vlm_me_l && !m_valid) n_miss = 1;
        m_miss = n_miss;
        chg = !m_init || (vlm_a != m_addr);
        if (chg) begin
            m_cs = 1; m_valid = 0;
        end else if (rom_ok && m_cs) begin
            m_buf = rom_data; m_valid = 1; m_cs = 0;
        end
        m_addr = vlm_a;
        m_init = 1;
        m_b2 = m_b1;
        m_b1 = vlm_bsy;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("vlm_st",   32'(vlm_st),   32'(m_active));
        chk("vlm_rst",  32'(vlm_rst),  32'(m_rst));
        chk("vlm_vcu",  32'(vlm_vcu),  32'(m_vcu));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("rom_cs",   32'(rom_cs),   32'(m_cs));
        chk("vlm_din",  32'(vlm_din),  32'(vlm_me_l ? m_data : m_buf));
        chk("bsy_rd",   32'(bsy_rd),   32'(m_b2));
        chk("miss",     32'(miss),     32'(m_miss));
    endtask

    task automatic cyc();
        if (vlm_st === 1'b1 && vlm_cen) st_ticks++;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic cpu_wr(input bit sel_ctrl, input logic [7:0] d);
        cpu_cen = 1; cpu_rnw = 0; data_cs = !sel_ctrl; ctrl_cs = sel_ctrl; cpu_dout = d;
        cyc();
        cpu_cen = 0; cpu_rnw = 1; data_cs = 0; ctrl_cs = 0;
    endtask

    task automatic async_rst();
        #3 rst_n = 0;
        #1 model_reset();
        check_all();
        chk("arst_rom_cs", 32'(rom_cs), 0);
        chk("arst_vlm_st", 32'(vlm_st), 0);
        cyc();
        rst_n = 1;
    endtask

    initial begin
        int cs_hi;
        model_reset();
        #1 rst_n = 0;
        #1 check_all();
        chk("reset_din", 32'(vlm_din), 32'h00);
        cyc();
        cyc();
        rst_n = 1;
        cyc();

        // short start request: pulse stretched to exactly ST_MIN ticks
        cpu_wr(0, 8'hA5);
        st_ticks = 0;
        cpu_wr(1, 8'h02);
        cpu_wr(1, 8'h00);
        for (int i = 0; i < 30; i++) begin
            vlm_cen = (i % 3 == 0);
            cyc();
        end
        vlm_cen = 0;
        chk("pulse_ticks", 32'(st_ticks), ST_MIN);
        chk("pulse_din", 32'(vlm_din), 32'hA5);
        chk("pulse_idle", 32'(vlm_st), 0);

        // reset bit during the pulse
        cpu_wr(1, 8'h02);
        cyc();
        cyc();
        chk("pulse_active", 32'(vlm_st), 1);
        cpu_wr(1, 8'h03);
        chk("vrst_rst", 32'(vlm_rst), 1);
        chk("vrst_st", 32'(vlm_st), 0);
        cyc();
        cpu_wr(1, 8'h00);
        cyc();

        // long request: held, falls one clock after the clearing write
        cpu_wr(1, 8'h02);
        for (int i = 0; i < 40; i++) begin
            vlm_cen = (i % 2 == 0);
            cyc();
        end
        vlm_cen = 0;
        cpu_wr(1, 8'h00);
        chk("hold_still", 32'(vlm_st), 1);
        cyc();
        chk("hold_fall", 32'(vlm_st), 0);

        // busy synchroniser
        vlm_bsy = 1; cyc();
        vlm_bsy = 0; cyc();
        chk("bsy_hi", 32'(bsy_rd), 1);
        cyc();
        chk("bsy_lo", 32'(bsy_rd), 0);

        // fetch with slow ROM, no chip sampling
        vlm_me_l = 0;
        vlm_a = 16'h1234; cyc();
        rom_ok = 1; cyc();
        rom_ok = 0; cyc();
        vlm_a = 16'h1235;
        cs_hi = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (rom_cs === 1'b1) cs_hi++;
        end
        rom_ok = 1; cyc();
        rom_ok = 0;
        chk("fetch_cs_len", 32'(cs_hi), 6);
        chk("fetch_cs_drop", 32'(rom_cs), 0);
        chk("fetch_din", 32'(vlm_din), 32'h7D);
        chk("fetch_nomiss", 32'(miss), 0);

        // stale answer ignored, early sample flagged
        vlm_a = 16'h2000; cyc(); cyc();
        vlm_a = 16'h2001; rom_ok = 1; cyc();
        rom_ok = 0;
        chk("stale_cs", 32'(rom_cs), 1);
        vlm_cen = 1; cyc();
        vlm_cen = 0; rom_ok = 1; cyc();
        rom_ok = 0;
        chk("stale_din", 32'(vlm_din), 32'h7B);
        chk("stale_miss", 32'(miss), 1);

        // reset in the middle of a fetch, restart after release
        vlm_a = 16'h3000; cyc();
        async_rst();
        cyc();
        chk("restart_cs", 32'(rom_cs), 1);
        chk("restart_addr", 32'(rom_addr), 32'h3000);

        // random traffic
        vlm_a = 16'hFFFE;
        for (int n = 0; n < 3000; n++) begin
            cpu_cen  = ($urandom % 4 == 0);
            cpu_rnw  = ($urandom % 3 == 0);
            data_cs  = ($urandom % 2 == 0);
            ctrl_cs  = !data_cs && ($urandom % 2 == 0);
            cpu_dout = 8'($urandom) & (($urandom % 4 == 0) ? 8'hFF : 8'hFE);
            vlm_cen  = ($urandom % 7 == 0);
            vlm_me_l = ($urandom % 3 == 0);
            vlm_bsy  = ($urandom % 2 == 0);
            rom_ok   = ($urandom % 3 == 0);
            if ($urandom % 8 == 0)
                vlm_a = ($urandom % 2 == 0) ? vlm_a + 1'b1 : AW'($urandom);
            if (n % 700 == 350) async_rst();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtyiear_vlm_if.md
JTYIEAR_VLM_IF -- requirements
Module: jtyiear_vlm_if

Interface
REQ-001 Parameter ST_MIN, default 4: minimum width of the VLM start pulse, counted in vlm_cen ticks.
REQ-002 Parameter AW, default 16: width of the speech ROM address.
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, 24 MHz.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 cpu_cen  in  1  CPU bus-cycle enable; all CPU writes are sampled only when it is high.
REQ-007 vlm_cen  in  1  VLM oscillator enable, 3.58 MHz.
REQ-008 cpu_rnw  in  1  CPU read-not-write.
REQ-009 cpu_dout  in  8  CPU write data.
REQ-010 data_cs  in  1  VLM data-latch select.
REQ-011 ctrl_cs  in  1  VLM control-register select.
REQ-012 vlm_a  in  AW  ROM address driven by the VLM.
REQ-013 vlm_me_l  in  1  VLM memory-enable, active-low.
REQ-014 vlm_bsy  in  1  VLM busy.
REQ-015 rom_addr  out  AW  speech ROM request address.
REQ-016 rom_cs  out  1  speech ROM request.
REQ-017 rom_data  in  8  speech ROM data.
REQ-018 rom_ok  in  1  rom_data is valid for rom_addr.
REQ-019 vlm_din  out  8  VLM data bus.
REQ-020 vlm_st  out  1  VLM start.
REQ-021 vlm_rst  out  1  VLM reset.
REQ-022 vlm_vcu  out  1  VLM VCU.
REQ-023 bsy_rd  out  1  busy bit for CPU readback, synchronised.
REQ-024 miss  out  1  sticky flag: the VLM sampled ROM data before it was valid.

Function
REQ-025 CPU write to data_cs (cpu_cen & ~cpu_rnw) SHALL load cpu_dout into the data latch on that clk edge.
REQ-026 CPU write to ctrl_cs SHALL load the control register: bit0 -> vlm_rst, bit1 -> st_req, bit2 -> vlm_vcu; bits 7:3 are ignored.
REQ-027 Selects with cpu_rnw=1 or cpu_cen=0 SHALL have no effect.
REQ-028 Start FSM states:
- IDLE: vlm_st=0.
- PULSE: vlm_st=1, counter cleared on entry, incremented per vlm_cen.
- HOLD: vlm_st=1.
REQ-029 Start FSM transitions:
- IDLE->PULSE on st_req rising edge.
- PULSE->HOLD when the counter reaches ST_MIN and st_req=1.
- PULSE->IDLE when the counter reaches ST_MIN and st_req=0.
- HOLD->IDLE when st_req=0.
REQ-030 vlm_st SHALL be registered and rise one clk after the write edge.
REQ-031 vlm_st SHALL stay high for at least ST_MIN vlm_cen ticks even if the CPU clears st_req earlier.
REQ-032 vlm_rst=1 SHALL force the FSM to IDLE and the counter to 0 in the same cycle, with priority over everything else.
REQ-033 A new st_req rising edge during PULSE or HOLD SHALL NOT restart the counter.
REQ-034 vlm_din SHALL be the data latch while vlm_me_l=1.
REQ-035 While vlm_me_l=0, vlm_din SHALL be the ROM buffer.
REQ-036 ROM fetch: rom_addr SHALL be vlm_a registered on each clk.
REQ-037 A change of vlm_a SHALL set rom_cs=1 and clear the buffer-valid flag on the next clk.
REQ-038 When rom_ok=1 with rom_cs=1 and rom_addr equal to the registered vlm_a, the block SHALL:
- capture rom_data into the buffer,
- set valid,
- drop rom_cs on the following clk.
REQ-039 rom_ok for a stale address (vlm_a changed meanwhile) SHALL be ignored; the request continues for the new address.
REQ-040 A vlm_cen tick with vlm_me_l=0 and valid=0 SHALL set miss; miss clears only on reset or a ctrl_cs write.
REQ-041 bsy_rd SHALL be vlm_bsy passed through a 2-flop synchroniser (2-clk latency).
REQ-042 Address wrap 0xFFFF->0x0000 SHALL be treated as an ordinary address change.

Reset
REQ-043 While rst_n=0, all of the following SHALL hold and be reached asynchronously:
- data latch = 0x00.
- control register = 0, so vlm_rst=0, vlm_vcu=0, st_req=0.
- FSM = IDLE, counter = 0.
- vlm_st=0, rom_cs=0, rom_addr=0, buffer=0x00, valid=0.
- miss=0, bsy_rd=0.
REQ-044 Reset deassertion mid-fetch SHALL restart the fetch from the first vlm_a sampled after release.

Verification
REQ-045 Scenario: write data_cs 0xA5, then ctrl_cs 0x02, then ctrl_cs 0x00 one cpu_cen later -> vlm_din=0xA5 and vlm_st high for exactly ST_MIN=4 vlm_cen ticks, then IDLE.
REQ-046 Scenario: ctrl_cs 0x02 held for 20 vlm_cen ticks, then 0x00 -> vlm_st high 20 ticks; falls 1 clk after the clearing write.
REQ-047 Scenario: in PULSE, write ctrl_cs 0x03 -> vlm_rst=1 and vlm_st=0 next clk; FSM IDLE.
REQ-048 Scenario: vlm_a 0x1234 -> 0x1235 with rom_ok returned after 6 clks -> rom_cs high 6 clks; vlm_din=rom_data while me_l=0; miss stays 0 when no vlm_cen tick falls in the window.
REQ-049 Scenario: vlm_a changes again before rom_ok -> first rom_ok ignored, buffer holds the second address data; a vlm_cen tick with me_l=0 before it sets miss=1.
REQ-050 Scenario: vlm_bsy pulses high 1 clk -> bsy_rd high 1 clk, 2 clks later; rst_n low mid-fetch -> all outputs return to reset values immediately.
